// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_ctrl
//  Description : Memory-mapped UART controller. Places a TX FIFO and an RX
//                FIFO between the core data bus and the UART_duplex
//                serializer. Bytes written to DATA are queued and launched
//                one at a time whenever the transmitter is free; bytes
//                received by the UART are captured automatically into the
//                RX FIFO. TX overflow and RX overrun are sticky flags.
//
//  Register map (word offsets, bus_addr):
//    0 DATA    W: push bus_wrdata[7:0] to TX FIFO
//              R: RX head byte (0 when empty), popped at the clock edge
//    1 STATUS  R: [0] tx_full   [1] tx_empty  [2] rx_full  [3] rx_empty
//                 [4] rx_overrun [5] tx_active [6] tx_overflow
//                 [15:8] tx_count [23:16] rx_count  (no side effects)
//    2 CONTROL W: [0] flush TX  [1] flush RX  [2] clear sticky flags
//              R: 0
//    3 reserved (reads 0, writes ignored)
//
//  Ports:
//    clk, rst            system clock, synchronous active-high reset
//    bus_sel             region select from the memory controller
//    bus_wren/bus_rden   write strobe / read (pop) strobe
//    bus_addr            word offset inside the region
//    bus_wrdata          write data
//    bus_rddata          combinational read data
//    uart_tx_data        byte presented to the UART transmitter
//    uart_tx_send        one-cycle launch pulse
//    uart_busy           UART transmitter busy
//    uart_rx_data        byte received by the UART
//    uart_rx_flag        UART byte-received flag
//    uart_rx_flag_clr    one-cycle flag-clear pulse
//
//  DATA_WIDTH must be at least 24 so the STATUS count fields fit.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_sel,
  input  logic                  bus_wren,
  input  logic                  bus_rden,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wrdata,
  output logic [DATA_WIDTH-1:0] bus_rddata,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_send,
  input  logic                  uart_busy,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_flag,
  output logic                  uart_rx_flag_clr
);

  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam int c_tx_cw = c_tx_aw + 1;
  localparam int c_rx_cw = c_rx_aw + 1;

  localparam logic [ADDR_WIDTH-1:0] c_addr_data   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl   = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    TX_IDLE       = 2'd0,
    TX_LAUNCH     = 2'd1,
    TX_WAIT_START = 2'd2,
    TX_WAIT_DONE  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_CLR  = 2'd1,
    RX_WAIT = 2'd2
  } rx_state_e;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [7:0]         tx_mem_q [TX_DEPTH];
  logic [c_tx_aw-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [c_tx_cw-1:0] tx_count_q,  tx_count_d;

  logic [7:0]         rx_mem_q [RX_DEPTH];
  logic [c_rx_aw-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [c_rx_cw-1:0] rx_count_q,  rx_count_d;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic [7:0]         tx_data_q,  tx_data_d;

  logic               tx_ovf_q, rx_ovr_q;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic wr_acc, rd_acc, sel_data, sel_status, sel_ctrl, ctrl_wr;
  logic tx_flush, rx_flush, sticky_clr;

  assign wr_acc     = bus_sel & bus_wren;
  assign rd_acc     = bus_sel & bus_rden;
  assign sel_data   = (bus_addr == c_addr_data);
  assign sel_status = (bus_addr == c_addr_status);
  assign sel_ctrl   = (bus_addr == c_addr_ctrl);
  assign ctrl_wr    = wr_acc & sel_ctrl;
  assign tx_flush   = ctrl_wr & bus_wrdata[0];
  assign rx_flush   = ctrl_wr & bus_wrdata[1];
  assign sticky_clr = ctrl_wr & bus_wrdata[2];

  // Only the payload byte and the three control bits are consumed.
  logic unused_wrdata_hi;
  assign unused_wrdata_hi = ^bus_wrdata[DATA_WIDTH-1:8];

  // --------------------------------------------------------------------------
  // FIFO status and push/pop qualification
  // --------------------------------------------------------------------------
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_ovf_set;
  logic rx_push, rx_pop, rx_ovr_set, rx_capture;

  assign tx_full  = (tx_count_q == c_tx_cw'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == c_rx_cw'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);

  // TX full check uses the pre-edge count, so a same-cycle FSM pop does not
  // make room for a bus push.
  assign tx_push    = wr_acc & sel_data & ~tx_full;
  assign tx_ovf_set = wr_acc & sel_data &  tx_full;

  // RX side: a bus pop in the same cycle frees the slot for the capture.
  assign rx_pop     = rd_acc & sel_data & ~rx_empty;
  assign rx_push    = rx_capture & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_capture &   rx_full & ~rx_pop;

  always_comb begin
    tx_count_d = tx_count_q + c_tx_cw'(tx_push) - c_tx_cw'(tx_pop);
    rx_count_d = rx_count_q + c_rx_cw'(rx_push) - c_rx_cw'(rx_pop);
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !uart_busy) begin
          tx_data_d  = tx_mem_q[tx_rd_ptr_q];
          tx_pop     = 1'b1;
          tx_state_d = TX_LAUNCH;
        end
      end
      TX_LAUNCH:     tx_state_d = TX_WAIT_START;
      TX_WAIT_START: if (uart_busy)  tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE:  if (!uart_busy) tx_state_d = TX_IDLE;
      default:       tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_tx_send = (tx_state_q == TX_LAUNCH);
  assign uart_tx_data = tx_data_q;

  // --------------------------------------------------------------------------
  // RX FSM: capture on the first sighting of the flag, then wait for the
  // UART to drop it so each assertion is taken exactly once.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_capture = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (uart_rx_flag) begin
          rx_capture = 1'b1;
          rx_state_d = RX_CLR;
        end
      end
      RX_CLR:  rx_state_d = RX_WAIT;
      RX_WAIT: if (!uart_rx_flag) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign uart_rx_flag_clr = (rx_state_q == RX_CLR);

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_data_q  <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_data_q  <= tx_data_d;
      // A new error on the clearing edge wins over the clear.
      tx_ovf_q   <= (tx_ovf_q & ~sticky_clr) | tx_ovf_set;
      rx_ovr_q   <= (rx_ovr_q & ~sticky_clr) | rx_ovr_set;
    end
  end

  // Flush overrides any push/pop on the same edge.
  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + c_tx_aw'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + c_tx_aw'(1);
      tx_count_q <= tx_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + c_rx_aw'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + c_rx_aw'(1);
      rx_count_q <= rx_count_d;
    end
  end

  // Storage arrays need no reset: contents are only visible via the pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus_wrdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= uart_rx_data;
  end

  // --------------------------------------------------------------------------
  // Read data mux
  // --------------------------------------------------------------------------
  always_comb begin
    bus_rddata = '0;
    if (sel_data) begin
      if (!rx_empty) bus_rddata[7:0] = rx_mem_q[rx_rd_ptr_q];
    end else if (sel_status) begin
      bus_rddata[0]     = tx_full;
      bus_rddata[1]     = tx_empty;
      bus_rddata[2]     = rx_full;
      bus_rddata[3]     = rx_empty;
      bus_rddata[4]     = rx_ovr_q;
      bus_rddata[5]     = (tx_state_q != TX_IDLE);
      bus_rddata[6]     = tx_ovf_q;
      bus_rddata[15:8]  = 8'(tx_count_q);
      bus_rddata[23:16] = 8'(rx_count_q);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo_ctrl
//  Description : Self-checking bench for uart_fifo_ctrl. A simple UART
//                transmitter model (fixed busy window per byte) and a
//                queue-based reference model of the FIFOs and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_wren, bus_rden;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wrdata, bus_rddata;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_send, uart_busy, uart_rx_flag, uart_rx_flag_clr;

  uart_fifo_ctrl #(
    .DATA_WIDTH(32), .TX_DEPTH(8), .RX_DEPTH(8), .ADDR_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_sel(bus_sel), .bus_wren(bus_wren), .bus_rden(bus_rden),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata),
    .uart_tx_data(uart_tx_data), .uart_tx_send(uart_tx_send),
    .uart_busy(uart_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_flag(uart_rx_flag), .uart_rx_flag_clr(uart_rx_flag_clr)
  );

  always #5 clk = ~clk;

  // ---------------- UART transmitter model and monitors --------------------
  bit         uart_auto;
  bit         busy_force;
  int         busy_cnt;
  int         clr_cnt;
  logic [7:0] sent[$];

  assign uart_busy = uart_auto ? (busy_cnt != 0) : busy_force;

  always @(negedge clk) begin
    if (uart_tx_send)     sent.push_back(uart_tx_data);
    if (uart_rx_flag_clr) clr_cnt++;
    if (rst) busy_cnt = 0;
    else if (uart_auto) begin
      if (uart_tx_send)      busy_cnt = BUSY_CYC;
      else if (busy_cnt > 0) busy_cnt--;
    end
  end

  // ---------------- checking ------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // ---------------- bus helpers (called at posedge+1) ----------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    bus_sel = 0; bus_wren = 0; bus_rden = 0; bus_addr = 0; bus_wrdata = 0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_sel = 1; bus_wren = 1; bus_rden = 0; bus_addr = a; bus_wrdata = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_sel = 1; bus_wren = 0; bus_rden = 1; bus_addr = a;
    #3 d = bus_rddata;
    step();
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    bus_idle();
    uart_rx_flag = 0;
    rst = 1;
    step(); step();
    rst = 0;
    sent.delete();
    clr_cnt = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_rx_data = b; uart_rx_flag = 1;
    step(); step();
    uart_rx_flag = 0;
    step(); step(); step();
  endtask

  // ---------------- reference model ----------------------------------------
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_ovf, m_ovr;

  function automatic logic [31:0] mstat();
    logic [31:0] s;
    s = '0;
    s[0]     = (txq.size() == 8);
    s[1]     = (txq.size() == 0);
    s[2]     = (rxq.size() == 8);
    s[3]     = (rxq.size() == 0);
    s[4]     = m_ovr;
    s[6]     = m_ovf;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  // ---------------- vector table --------------------------------------------
  typedef struct {
    bit          wr;
    bit          rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, bit rd, logic [1:0] a, logic [31:0] d,
                              bit chk, logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  // ---------------- test sequence ------------------------------------------
  initial begin
    logic [31:0] d;
    int          rx_hi_left, rx_lo_left;
    bit          flag_prev, exp_clr;

    rst = 1; uart_auto = 0; busy_force = 1; busy_cnt = 0; clr_cnt = 0;
    uart_rx_data = 0; uart_rx_flag = 0;
    bus_idle();
    #1;

    // ---- reset state
    do_reset();
    #3 check("reset_outputs", {22'd0, uart_tx_data, uart_tx_send, uart_rx_flag_clr}, 32'd0);
    step();
    read_check("reset_status", 2'd1, 32'h0000000A);

    // ---- three-byte transmission with a 10-cycle busy window
    uart_auto = 1;
    do_reset();
    bus_write(2'd0, 32'h41); bus_write(2'd0, 32'h42); bus_write(2'd0, 32'h43);
    for (int i = 0; i < 300 && !(sent.size() == 3 && busy_cnt == 0); i++) step();
    step(); step(); step();
    check("tx3_pulses", sent.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("tx3_byte%0d", i), (i < sent.size()) ? {24'd0, sent[i]} : 32'hX, 32'h41 + i);
    read_check("tx3_status_idle", 2'd1, 32'h0000000A);

    // ---- table: overflow with transmitter held busy, register map
    uart_auto = 0; busy_force = 1;
    do_reset();
    vecs.delete();
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 32'h0000000A));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(1, 0, 2'd0, 32'hABCD_0010 + i, 0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 32'h00000849));
    vecs.push_back(mk(0, 1, 2'd0, 0, 1, 32'h00000000));
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 32'h00000849));
    vecs.push_back(mk(0, 1, 2'd2, 0, 1, 32'h00000000));
    vecs.push_back(mk(0, 1, 2'd3, 0, 1, 32'h00000000));
    vecs.push_back(mk(1, 0, 2'd3, 32'hFFFFFFFF, 0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 32'h00000849));
    vecs.push_back(mk(1, 0, 2'd2, 32'h4, 0, 0));
    vecs.push_back(mk(0, 1, 2'd1, 0, 1, 32'h00000809));
    foreach (vecs[i]) begin
      bus_sel = 1; bus_wren = vecs[i].wr; bus_rden = vecs[i].rd;
      bus_addr = vecs[i].addr; bus_wrdata = vecs[i].wdata;
      #3;
      if (vecs[i].chk) check($sformatf("table_row%0d", i), bus_rddata, vecs[i].exp);
      step();
    end
    bus_idle();
    check("ovf_no_send_while_busy", sent.size(), 0);
    uart_auto = 1;
    for (int i = 0; i < 400 && sent.size() < 9; i++) step();
    check("ovf_drain_count", sent.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("ovf_drain_byte%0d", i), (i < sent.size()) ? {24'd0, sent[i]} : 32'hX, 32'h10 + i);

    // ---- RX flag held 5 cycles: captured once
    do_reset();
    uart_rx_data = 8'h5A; uart_rx_flag = 1;
    repeat (5) step();
    uart_rx_flag = 0;
    repeat (3) step();
    check("rx_single_clr_pulse", clr_cnt, 1);
    read_check("rx_single_status", 2'd1, 32'h00010002);
    read_check("rx_single_data", 2'd0, 32'h0000005A);
    read_check("rx_single_empty", 2'd1, 32'h0000000A);

    // ---- RX overrun
    do_reset();
    for (int i = 0; i < 9; i++) rx_byte(8'h80 + 8'(i));
    read_check("rx_overrun_status", 2'd1, 32'h00080016);

    // ---- 9th byte on the same cycle as a DATA read: accepted
    do_reset();
    for (int i = 0; i < 8; i++) rx_byte(8'h90 + 8'(i));
    uart_rx_data = 8'h98; uart_rx_flag = 1;
    bus_sel = 1; bus_rden = 1; bus_addr = 2'd0;
    #3 check("rx_full_pop_data", bus_rddata, 32'h90);
    step();
    bus_idle();
    step();
    uart_rx_flag = 0;
    repeat (3) step();
    read_check("rx_full_pop_status", 2'd1, 32'h00080006);
    for (int i = 1; i <= 8; i++) read_check($sformatf("rx_drain%0d", i), 2'd0, 32'h90 + i);
    read_check("rx_empty_read", 2'd0, 32'h0);
    read_check("rx_empty_read_status", 2'd1, 32'h0000000A);
    rx_byte(8'h33);
    read_check("rx_after_empty_read", 2'd0, 32'h33);

    // ---- flush TX during the first byte's busy window
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h61 + i);
    for (int i = 0; i < 50 && !uart_busy; i++) step();
    bus_write(2'd2, 32'h1);
    repeat (60) step();
    check("flush_one_send", sent.size(), 1);
    check("flush_first_byte", (sent.size() > 0) ? {24'd0, sent[0]} : 32'hX, 32'h61);
    read_check("flush_status", 2'd1, 32'h0000000A);

    // ---- reset mid-transmission
    do_reset();
    bus_write(2'd0, 32'h71); bus_write(2'd0, 32'h72);
    for (int i = 0; i < 50 && !uart_busy; i++) step();
    rst = 1; step(); rst = 0;
    repeat (40) step();
    check("reset_mid_sends", sent.size(), 1);
    read_check("reset_mid_status", 2'd1, 32'h0000000A);

    // ---- randomized traffic against the queue model (transmitter held busy)
    uart_auto = 0; busy_force = 1;
    do_reset();
    txq.delete(); rxq.delete(); m_ovf = 0; m_ovr = 0;
    flag_prev = 0; exp_clr = 0; rx_hi_left = 0; rx_lo_left = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int  op;
      bit  wr_ok, rd_ok, capture, pop;
      // RX flag stimulus: high 1..3 cycles, then low at least 3 cycles
      if (rx_hi_left > 0) begin
        uart_rx_flag = 1; rx_hi_left--;
        if (rx_hi_left == 0) rx_lo_left = 3;
      end else if (rx_lo_left > 0) begin
        uart_rx_flag = 0; rx_lo_left--;
      end else if ($urandom_range(0, 2) == 0) begin
        uart_rx_flag = 1; uart_rx_data = 8'($urandom);
        rx_hi_left = $urandom_range(1, 3) - 1;
        if (rx_hi_left == 0) rx_lo_left = 3;
      end else uart_rx_flag = 0;

      bus_idle();
      op = $urandom_range(0, 10);
      case (op)
        0, 1, 2: begin bus_sel = 1; bus_wren = 1; bus_addr = 0; bus_wrdata = $urandom; end
        3, 4, 5: begin bus_sel = 1; bus_rden = 1; bus_addr = 0; end
        6:       begin bus_sel = 1; bus_rden = 1; bus_addr = 1; end
        7:       begin bus_sel = 1; bus_wren = 1; bus_addr = 2; bus_wrdata = $urandom_range(0, 7); end
        8:       begin bus_sel = 1; bus_rden = 1; bus_addr = 2'($urandom_range(2, 3)); end
        9:       begin bus_sel = 0; bus_wren = 1; bus_rden = 1; bus_addr = 2'($urandom); bus_wrdata = $urandom; end
        default: ;
      endcase
      #3;
      wr_ok = bus_sel & bus_wren;
      rd_ok = bus_sel & bus_rden;
      if (rd_ok) begin
        if (bus_addr == 0)      check("rand_data", bus_rddata, (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0);
        else if (bus_addr == 1) check("rand_status", bus_rddata, mstat());
        else                    check("rand_zero_reg", bus_rddata, 32'd0);
      end
      check("rand_rx_flag_clr", {31'd0, uart_rx_flag_clr}, {31'd0, exp_clr});

      // model update for this edge
      capture   = uart_rx_flag && !flag_prev;
      flag_prev = uart_rx_flag;
      exp_clr   = capture;
      pop       = rd_ok && bus_addr == 0 && rxq.size() > 0;
      if (wr_ok && bus_addr == 2 && bus_wrdata[2]) begin m_ovf = 0; m_ovr = 0; end
      if (pop) void'(rxq.pop_front());
      if (capture) begin
        if (rxq.size() < 8) rxq.push_back(uart_rx_data);
        else m_ovr = 1;
      end
      if (wr_ok && bus_addr == 0) begin
        if (txq.size() < 8) txq.push_back(bus_wrdata[7:0]);
        else m_ovf = 1;
      end
      if (wr_ok && bus_addr == 2 && bus_wrdata[0]) txq.delete();
      if (wr_ok && bus_addr == 2 && bus_wrdata[1]) rxq.delete();
      step();
    end
    bus_idle();
    uart_rx_flag = 0;
    repeat (4) step();
    read_check("rand_final_status", 2'd1, mstat());
    check("rand_no_send_while_busy", sent.size(), 0);
    uart_auto = 1;
    for (int i = 0; i < 400 && sent.size() < txq.size(); i++) step();
    repeat (30) step();
    check("rand_tx_count", sent.size(), txq.size());
    foreach (txq[i])
      check($sformatf("rand_tx_byte%0d", i), (i < sent.size()) ? {24'd0, sent[i]} : 32'hX, {24'd0, txq[i]});
    foreach (rxq[i]) read_check($sformatf("rand_rx_byte%0d", i), 2'd0, {24'd0, rxq[i]});
    read_check("rand_rx_empty", 2'd1, {m_ovr ? 32'h10 : 32'h0} | 32'h0000000A | {25'd0, m_ovf, 6'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Memory-mapped UART controller that puts parametrised TX and RX FIFOs between the core's data bus and the existing UART_duplex serializer. It replaces direct tx_send/uart_busy polling by firmware: the core queues up to TX_DEPTH bytes without stalling, and received bytes are captured automatically into the RX FIFO. Overflow and overrun are reported through sticky status flags. The memory controller instantiates it behind one address region; the selected region drives the bus_sel input.

Parameters:
DATA_WIDTH, 32, bus data width; only bits [7:0] carry UART payload.
TX_DEPTH, 8, TX FIFO entries; power of two, 2..128.
RX_DEPTH, 8, RX FIFO entries; power of two, 2..128.
ADDR_WIDTH, 2, word-offset width within the region.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bus_sel  in  1  region selected by memory controller
bus_wren  in  1  write strobe
bus_rden  in  1  read strobe (pop qualifier)
bus_addr  in  ADDR_WIDTH  word offset: 0=DATA, 1=STATUS, 2=CONTROL, 3=reserved
bus_wrdata  in  DATA_WIDTH  write data
bus_rddata  out  DATA_WIDTH  combinational read data
uart_tx_data  out  8  byte presented to UART_duplex Tx_Data
uart_tx_send  out  1  one-cycle launch pulse
uart_busy  in  1  UART transmitter busy
uart_rx_data  in  8  received byte
uart_rx_flag  in  1  UART byte-received flag
uart_rx_flag_clr  out  1  one-cycle flag-clear pulse

Behaviour:
- Reset: both FIFOs empty; all pointers and counts 0; sticky flags 0; TX FSM=TX_IDLE; RX FSM=RX_IDLE; uart_tx_data=0; uart_tx_send=0; uart_rx_flag_clr=0.
- A write is accepted when bus_sel & bus_wren. A pop is accepted when bus_sel & bus_rden. Both take effect at the clock edge.
- DATA write: pushes bus_wrdata[7:0] into TX FIFO. If TX FIFO is full: byte dropped, tx_overflow sticky set.
- DATA read: bus_rddata = {zeros, RX head byte}, and the pop occurs at the edge. If RX FIFO is empty: returns 0, no pop, no flag change.
- STATUS read (no side effects): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 rx_overrun, bit5 tx_active (TX FSM not TX_IDLE), bit6 tx_overflow, [15:8] tx_count, [23:16] rx_count; other bits 0.
- CONTROL write: bit0 flushes TX FIFO, bit1 flushes RX FIFO, bit2 clears both sticky flags. Bits are self-clearing. CONTROL reads 0. Reserved offset: reads 0, writes ignored.
- TX FSM:
  - TX_IDLE -> TX_LAUNCH when the FIFO is non-empty and uart_busy=0. On this transition, latch the head into uart_tx_data and pop.
  - TX_LAUNCH: uart_tx_send=1 for exactly this cycle -> TX_WAIT_START.
  - TX_WAIT_START -> TX_WAIT_DONE when uart_busy=1.
  - TX_WAIT_DONE -> TX_IDLE when uart_busy=0.
  - Minimum gap between launch pulses: 4 cycles plus UART frame time.
- RX FSM:
  - RX_IDLE -> RX_CLR when uart_rx_flag=1. On this transition, push uart_rx_data. If the FIFO is full and no pop occurs that cycle: byte dropped, rx_overrun set.
  - RX_CLR: uart_rx_flag_clr=1 for one cycle -> RX_WAIT.
  - RX_WAIT -> RX_IDLE when uart_rx_flag=0.
  - Each flag assertion is captured exactly once.
- Simultaneous events:
  - RX push + bus pop in the same cycle are both performed; count unchanged. When the FIFO is full, the push is accepted because of the pop.
  - TX bus push + FSM pop in the same cycle are both performed. When the TX FIFO is full, the push is still dropped (push full-check uses the pre-edge count).
  - Flush and push on the same edge: flush wins; FIFO empty afterwards.
  - Sticky clear and a new error event on the same edge: the flag is set.
- Flush TX during transmission: the in-flight byte completes; the FSM continues its sequence; remaining bytes are discarded.
- Reset mid-operation: everything returns to reset values next edge; no further tx_send until a new push.
- Pointers wrap modulo depth. Counts are log2(depth)+1 bits wide, zero-extended into the 8-bit status fields.

Test Plan:
- Reset, then write DATA 0x41, 0x42, 0x43, with uart_busy modelled at 10 cycles per byte -> exactly three tx_send pulses carrying 0x41, 0x42, 0x43 in order; STATUS bit1=1 and bit5=0 at the end.
- With uart_busy held 1, write 9 bytes (TX_DEPTH=8) -> tx_count=8, tx_overflow=1, 9th byte never transmitted; CONTROL write 0x4 clears bit6.
- Assert uart_rx_flag with 0x5A and hold it for 5 cycles -> single push, one uart_rx_flag_clr pulse; STATUS rx_count=1; DATA read returns 0x0000005A, then rx_empty=1.
- Fill RX with 8 bytes, then deliver a 9th with no read -> rx_overrun=1, rx_count=8. Repeat, delivering the 9th on the same cycle as a DATA read -> accepted, overrun stays 0.
- Read DATA with RX empty -> returns 0; pointers unchanged; no flags set.
- Queue 4 bytes, then write CONTROL 0x1 during the first byte's busy window -> first byte completes; no further tx_send; tx_count=0.
